serial_add_ctrl: RTL and testbench

//   Bit-serial adder controller. Latches two WIDTH-bit operands on a start strobe and

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_fa_bit.sv | 21 ++
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int CNT_W(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full adder cell made of two half adders and an OR; purely
// combinational, all sequencing state lives in the controller.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ cin;
    assign ha1_c = ha0_s & cin;
    assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: latches a/b on start and feeds one full-adder
// cell LSB first for WIDTH cycles. Optional subtract mode: SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_r;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    logic             accept_s;
    logic             last_s;
    logic             bit_sum_s;
    logic             bit_carry_s;
    logic [WIDTH-1:0] b_lat_s;
    logic             carry_init_s;
    logic [WIDTH:0]   sum_cat_s;
    logic [WIDTH-1:0] sum_shift_s;

    serial_fa_bit u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .s    (bit_sum_s),
        .cout (bit_carry_s)
    );

    assign accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_s      = (state_r == ST_RUN) && (cnt_r == CNT_LAST);
    assign sum_cat_s   = {bit_sum_s, sum_sh_r};
    assign sum_shift_s = sum_cat_s[WIDTH:1];

    // Operand B conditioning: two's-complement subtract inverts B and seeds carry.
    always_comb begin
        b_lat_s      = b;
        carry_init_s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            b_lat_s      = ~b;
            carry_init_s = 1'b1;
        end else begin
            b_lat_s      = b;
            carry_init_s = 1'b0;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx = ST_RUN;
                else       state_nx = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_nx = ST_DONE;
                else        state_nx = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_nx = ST_RUN;
                else       state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            busy_r  <= (state_nx == ST_RUN);
            done_r  <= (state_nx == ST_DONE);
        end
    end

    // Serial datapath; the visible result only changes on the final RUN bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            sum_r    <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b_lat_s;
            sum_sh_r <= {WIDTH{1'b0}};
            carry_r  <= carry_init_s;
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            a_sh_r   <= a_sh_r >> 1;
            b_sh_r   <= b_sh_r >> 1;
            sum_sh_r <= sum_shift_s;
            carry_r  <= bit_carry_s;
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_s) begin
                sum_r  <= sum_shift_s;
                cout_r <= bit_carry_s;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes arithmetic expectations
// with their due cycle, a negedge monitor checks busy/done/sum/cout against them.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub_v = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int cyc   = 0;
    int nchk  = 0;
    int npass = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_v),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int n);
        exp_t r;
        int   ix, iy, t, m;
        ix = int'(x);
        iy = int'(y);
        m  = 1 << W;
        if (s) begin
            t      = ix - iy + m;
            r.cout = (ix >= iy);
        end else begin
            t      = ix + iy;
            r.cout = (t >= m);
        end
        r.sum = W'(t % m);
        r.due = n + W + 1;
        return r;
    endfunction

    // Monitor: compares every negedge against the scoreboard head / held result.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst) begin
            chk("reset_outputs", {29'd0, busy, done, cout} | 32'(sum), 32'd0);
            sbq.delete();
            last_sum  = '0;
            last_cout = 1'b0;
        end else begin
            exp_busy = (sbq.size() > 0) && (cyc >= sbq[0].due - W) && (cyc < sbq[0].due);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (done) begin
                chk("busy_with_done", 32'(busy), 32'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_latency", 32'(cyc), 32'(e.due));
                    chk("sum", 32'(sum), 32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    last_sum  = e.sum;
                    last_cout = e.cout;
                end
            end else begin
                chk("sum_held", 32'(sum), 32'(last_sum));
                chk("cout_held", 32'(cout), 32'(last_cout));
                if (sbq.size() > 0 && cyc > sbq[0].due) begin
                    chk("done_timeout", 32'd1, 32'd0);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // Issue one operation at the current negedge; optionally pulse a stray start
    // during RUN cycle pulse_at. Returns at the negedge where done is visible.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input int pulse_at);
        start = 1'b1;
        a     = x;
        b     = y;
        sub_v = s;
        sbq.push_back(model(x, y, s, cyc));
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            if (i == pulse_at) begin
                start = 1'b1;
                a     = '0;
                b     = '0;
            end else begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [W-1:0] x, y;
        logic         s;
        int           gap;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic add and latency
        do_op(8'h5A, 8'h33, 1'b0, -1);
        @(negedge clk);
        // 2: full carry-out, then held for 20 idle cycles
        do_op(8'hFF, 8'h01, 1'b0, -1);
        repeat (20) @(negedge clk);
        // 3: stray start during RUN cycle 3
        do_op(8'h5A, 8'h33, 1'b0, 3);
        repeat (2) @(negedge clk);

        // 4: async reset mid-run
        start = 1'b1; a = 8'h5A; b = 8'h33; sub_v = 1'b0;
        sbq.push_back(model(8'h5A, 8'h33, 1'b0, cyc));
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset_immediate", {29'd0, busy, done, cout} | 32'(sum), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(8'h01, 8'h01, 1'b0, -1);
        @(negedge clk);

        // 5: start held high through RUN into DONE -> back-to-back
        start = 1'b1; a = 8'h12; b = 8'h34; sub_v = 1'b0;
        sbq.push_back(model(8'h12, 8'h34, 1'b0, cyc));
        repeat (W) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        a = 8'hC8; b = 8'h64;
        sbq.push_back(model(8'hC8, 8'h64, 1'b0, cyc));
        repeat (W + 1) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
        // 6: subtraction
        do_op(8'h10, 8'h01, 1'b1, -1);
        @(negedge clk);
        do_op(8'h00, 8'h01, 1'b1, -1);
        @(negedge clk);
`endif

        // Random operations with random idle gaps (gap 0 restarts from DONE)
        for (int k = 0; k < 30; k++) begin
            x = W'($urandom);
            y = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            do_op(x, y, s, (k % 5 == 0) ? int'($urandom_range(0, W - 2)) : -1);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        repeat (W + 4) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", npass, nchk);
        $fatal(1);
    end

endmodule
